// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory for the IF stage: clear-on-reset sweep,
// runtime program-load port and a registered fetch output with stall/flush.
module inst_mem_sync #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic                  fetch_req,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  inst_valid,
  output logic                  addr_err,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_wa_s;
  logic [DATA_WIDTH-1:0]   mem_wd_s;

  logic [ADDR_WIDTH-1:0]   idx_s;
  logic                    range_err_s;

  logic [DATA_WIDTH-1:0]   instr_r;
  logic                    valid_r;
  logic                    err_r;
  logic                    ready_r;
  logic [DATA_WIDTH-1:0]   instr_s;
  logic                    valid_s;
  logic                    err_s;

  // Out-of-range is flagged, never aliased onto a lower word.
  assign idx_s       = Address[ADDR_WIDTH+1:2];
  assign range_err_s = (Address[1:0] != 2'b00) ||
                       ((Address >> (ADDR_WIDTH + 2)) != 32'd0);

  // Next-state: the sweep leaves CLEAR after writing the last index.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep and the program loader.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = cnt_r;
    mem_wd_s = NOP_WORD;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        mem_wa_s = cnt_r;
        mem_wd_s = NOP_WORD;
      end
      ST_RUN: begin
        if (load_en) begin
          mem_we_s = 1'b1;
          mem_wa_s = load_addr;
          mem_wd_s = load_data;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: mem_we_s = 1'b0;
    endcase
  end

  // Fetch output next value; flush beats stall, stall beats a new fetch.
  always_comb begin
    instr_s = instr_r;
    valid_s = valid_r;
    err_s   = err_r;
    if (state_r != ST_RUN) begin
      instr_s = NOP_WORD;
      valid_s = 1'b0;
      err_s   = 1'b0;
    end else if (flush) begin
      instr_s = NOP_WORD;
      valid_s = 1'b0;
      err_s   = 1'b0;
    end else if (stall) begin
      instr_s = instr_r;
      valid_s = valid_r;
      err_s   = err_r;
    end else if (fetch_req) begin
      if (range_err_s) begin
        instr_s = NOP_WORD;
        valid_s = 1'b1;
        err_s   = 1'b1;
      end else begin
        instr_s = mem_r[idx_s];
        valid_s = 1'b1;
        err_s   = 1'b0;
      end
    end else begin
      instr_s = NOP_WORD;
      valid_s = 1'b0;
      err_s   = 1'b0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      instr_r <= NOP_WORD;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= (state_r == ST_CLEAR) ? cnt_r + CNT_ONE : cnt_r;
      instr_r <= instr_s;
      valid_r <= valid_s;
      err_r   <= err_s;
      ready_r <= (state_s == ST_RUN);
    end
  end

  // Storage is not reset; the sweep initialises it. Reads see pre-write data.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  assign Instruction = instr_r;
  assign inst_valid  = valid_r;
  assign addr_err    = err_r;
  assign ready       = ready_r;

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
Parametrised, synchronous-read instruction memory for the pipelined MIPS core, replacing the fixed combinational ROM. It adds a runtime program-load port, a clear-on-reset sweep, and registered fetch output with stall/flush control for the IF stage. Fetch addresses are byte addresses; words are indexed by Address[ADDR_WIDTH+1:2].

Parameters:
ADDR_WIDTH, 8, word-index width; depth DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width
NOP_WORD, 32'h0, value written by clear sweep and driven on flush/error

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
Address  input  32  byte fetch address from PC
fetch_req  input  1  fetch request this cycle
stall  input  1  hold IF output register
flush  input  1  squash IF output (branch/jump taken)
load_en  input  1  program-load write strobe
load_addr  input  ADDR_WIDTH  word index for load
load_data  input  DATA_WIDTH  word to load
Instruction  output  DATA_WIDTH  registered fetched word
inst_valid  output  1  Instruction holds a real fetch
addr_err  output  1  registered: last fetch out of range or misaligned
ready  output  1  memory initialised, fetches/loads accepted

Behaviour:
- Reset (async): Instruction=NOP_WORD, inst_valid=0, addr_err=0, ready=0, sweep counter=0, FSM -> CLEAR. Memory contents not reset directly.
- FSM CLEAR: each cycle write NOP_WORD to mem[counter], counter++; after writing index DEPTH-1 go to RUN next cycle (exactly DEPTH cycles in CLEAR). ready=0 throughout; fetch_req and load_en ignored; outputs hold reset values.
- FSM RUN: ready=1. Stays until reset. Reset asserted mid-RUN or mid-CLEAR restarts CLEAR from index 0; any partial load is discarded by the sweep.
- Load: in RUN, load_en=1 writes load_data to mem[load_addr] at clock edge. Visible to fetches issued the following cycle or later.
- Fetch latency 1: fetch_req=1 at edge N (RUN, stall=0, flush=0) -> Instruction/inst_valid updated after edge N.
- Range check: error if Address[1:0]!=0 or Address[31:ADDR_WIDTH+2]!=0. On error: Instruction=NOP_WORD, inst_valid=1, addr_err=1. Otherwise Instruction=mem[Address[ADDR_WIDTH+1:2]], addr_err=0.
- fetch_req=0 (no stall/flush): Instruction=NOP_WORD, inst_valid=0, addr_err=0.
- stall=1: Instruction, inst_valid, addr_err hold; no read captured; loads still performed.
- flush=1: priority over stall and fetch_req; next cycle Instruction=NOP_WORD, inst_valid=0, addr_err=0.
- Same-cycle load and fetch to same word: fetch returns old contents (read-before-write).
- Address wrap: none; out-of-range is an error, not aliased.

Test Plan:
- Reset, hold 0, ADDR_WIDTH=4 -> ready=0 for exactly 16 cycles, then 1; fetch of 0x00..0x3C all return 32'h0, inst_valid=1.
- Load mem[3]=32'h2084fffb, then fetch_req with Address=0x0C -> next cycle Instruction=32'h2084fffb, inst_valid=1, addr_err=0.
- Same cycle: load mem[2]=32'h10800002 while fetching 0x08 (old 32'h0) -> Instruction=32'h0; fetch 0x08 again next cycle -> 32'h10800002.
- Fetch Address=0x0A, then Address=0x40 (ADDR_WIDTH=4) -> each: Instruction=32'h0, addr_err=1, inst_valid=1.
- Fetch 0x0C (valid), then stall=1 for 3 cycles with Address changing -> Instruction stays 32'h2084fffb; assert stall+flush together -> next cycle inst_valid=0, Instruction=32'h0.
- Assert reset during RUN after loads -> outputs return to reset values immediately; ready=0 for DEPTH cycles; fetch 0x0C afterwards returns 32'h0.
